// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write path.
package regfile_pkg;

  localparam int RF_DEPTH  = 8;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   j;

  // First asserted request at or after ptr wins; one-hot grant plus its index.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port controller: init sweep after reset, then
// round-robin sharing of the port among NUM_REQ requesters.
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int                NUM_REQ    = 2,
  parameter int                DATA_W     = RF_DATA_W,
  parameter int                ADDR_W     = RF_ADDR_W,
  parameter int                DEPTH      = RF_DEPTH,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter int                GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic [GID_W-1:0]          grant_id,
  output logic                      init_done,
  output logic                      addr_err
);

  // Counter must reach DEPTH itself: that value marks "sweep finished".
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   init_cnt, init_cnt_n;
  logic [GID_W-1:0]   rr_ptr, rr_ptr_n;
  logic               we_n, err_n, done_n;
  logic [ADDR_W-1:0]  wreg_n;
  logic [DATA_W-1:0]  data_n;
  logic [GID_W-1:0]   gid_n;

  logic [NUM_REQ-1:0]             arb_req, grant;
  logic [GID_W-1:0]               gnt_idx;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_v;
  logic [ADDR_W-1:0]              sel_addr;
  logic [DATA_W-1:0]              sel_data;

  assign addr_v   = req_addr;
  assign data_v   = req_data;
  assign arb_req  = req_valid & {NUM_REQ{state == ST_RUN}};
  assign req_ready = grant;
  assign sel_addr = addr_v[gnt_idx];
  assign sel_data = data_v[gnt_idx];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(GID_W)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  // Next state and next registered port values; port fields hold by default.
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    rr_ptr_n   = rr_ptr;
    we_n       = 1'b0;
    wreg_n     = write_reg;
    data_n     = write_data;
    gid_n      = grant_id;
    done_n     = init_done;
    err_n      = 1'b0;
    case (state)
      ST_INIT: begin
        // One cycle after the last sweep write is on the port, open for requests.
        if (init_cnt == CNT_W'(DEPTH)) begin
          state_n = ST_RUN;
          done_n  = 1'b1;
        end else begin
          we_n       = 1'b1;
          wreg_n     = ADDR_W'(init_cnt);
          data_n     = INIT_VALUE;
          init_cnt_n = init_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (|grant) begin
          rr_ptr_n = (gnt_idx == GID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + GID_W'(1);
          // Out-of-range targets are consumed but never reach the register file.
          if (sel_addr < ADDR_W'(DEPTH)) begin
            we_n   = 1'b1;
            wreg_n = sel_addr;
            data_n = sel_data;
            gid_n  = gnt_idx;
          end else begin
            err_n = 1'b1;
          end
        end
      end
    endcase
  end

  // State and port registers; reset drops any accepted-but-unissued write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      rr_ptr     <= '0;
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      grant_id   <= '0;
      init_done  <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state      <= state_n;
      init_cnt   <= init_cnt_n;
      rr_ptr     <= rr_ptr_n;
      RegWrite   <= we_n;
      write_reg  <= wreg_n;
      write_data <= data_n;
      grant_id   <= gid_n;
      init_done  <= done_n;
      addr_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl with a shadow register file.
module tb_regfile_write_ctrl;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0][4:0] a_v;
  logic [1:0][31:0] d_v;
  logic [9:0]      req_addr;
  logic [63:0]     req_data;
  logic [1:0]      req_ready;
  logic            RegWrite;
  logic [4:0]      write_reg;
  logic [31:0]     write_data;
  logic [0:0]      grant_id;
  logic            init_done;
  logic            addr_err;

  logic [31:0] mrf [8];
  int checks = 0;
  int errors = 0;

  assign req_addr = a_v;
  assign req_data = d_v;

  always #5 clk = ~clk;

  regfile_write_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .RegWrite   (RegWrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .grant_id   (grant_id),
    .init_done  (init_done),
    .addr_err   (addr_err)
  );

  // Shadow register file commits on the edge ending each write cycle.
  always @(posedge clk)
    if (RegWrite) mrf[write_reg[2:0]] <= write_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_init();
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("init_we", RegWrite, 1);
      chk("init_reg", write_reg, k - 1);
      chk("init_data", write_data, 0);
      chk("init_done_lo", init_done, 0);
      chk("init_rdy", req_ready, 0);
    end
    req_valid = 2'b00;
    step();
    chk("init_done_hi", init_done, 1);
    chk("post_init_we", RegWrite, 0);
  endtask

  logic [1:0]  exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] exp_dat [4] = '{32'h100, 32'h200, 32'h101, 32'h201};

  initial begin
    for (int i = 0; i < 8; i++) mrf[i] = 32'hFFFF_FFFF;
    reset = 1'b1; req_valid = 2'b00; a_v = '0; d_v = '0;
    step(); step();
    chk("rst_we", RegWrite, 0);
    chk("rst_reg", write_reg, 0);
    chk("rst_data", write_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_done", init_done, 0);
    chk("rst_err", addr_err, 0);

    // Init sweep with both requesters pushing: ready must stay low.
    reset = 1'b0; req_valid = 2'b11;
    #1 chk("c0_rdy", req_ready, 0);
    run_init();
    for (int i = 0; i < 8; i++) chk("init_mrf", mrf[i], 0);

    // Single request from requester 0.
    req_valid = 2'b01; a_v[0] = 5'd3; d_v[0] = 32'h5;
    #1 chk("single_rdy", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    chk("single_we", RegWrite, 1);
    chk("single_reg", write_reg, 3);
    chk("single_data", write_data, 32'h5);
    chk("single_gid", grant_id, 0);
    step();
    chk("single_we_off", RegWrite, 0);
    chk("single_hold", write_data, 32'h5);

    // Pointer is now 1: requester 1 alone brings it back to 0.
    req_valid = 2'b10; a_v[1] = 5'd4; d_v[1] = 32'h44;
    #1 chk("r1_rdy", req_ready, 2'b10);
    step(); req_valid = 2'b00;
    chk("r1_gid", grant_id, 1);
    chk("r1_data", write_data, 32'h44);

    // Contention: alternating grants, granted requester moves to next data.
    req_valid = 2'b11; a_v[0] = 5'd5; a_v[1] = 5'd6;
    d_v[0] = 32'h100; d_v[1] = 32'h200;
    for (int c = 0; c < 4; c++) begin
      #1 chk("cont_rdy", req_ready, exp_rdy[c]);
      step();
      if (exp_rdy[c][0]) d_v[0] = d_v[0] + 1; else d_v[1] = d_v[1] + 1;
      if (c == 3) req_valid = 2'b00;
      chk("cont_we", RegWrite, 1);
      chk("cont_gid", grant_id, exp_rdy[c][1]);
      chk("cont_data", write_data, exp_dat[c]);
    end
    step();
    chk("cont_mrf5", mrf[5], 32'h101);
    chk("cont_mrf6", mrf[6], 32'h201);

    // Same address from both: later grant (req1) persists.
    req_valid = 2'b11; a_v[0] = 5'd2; a_v[1] = 5'd2; d_v[0] = 32'hA; d_v[1] = 32'hB;
    #1 chk("same_rdy0", req_ready, 2'b01);
    step(); req_valid = 2'b10;
    chk("same_d0", write_data, 32'hA);
    #1 chk("same_rdy1", req_ready, 2'b10);
    step(); req_valid = 2'b00;
    chk("same_we1", RegWrite, 1);
    chk("same_d1", write_data, 32'hB);
    step();
    chk("same_mrf2", mrf[2], 32'hB);

    // Out-of-range target from requester 1.
    req_valid = 2'b10; a_v[1] = 5'd9; d_v[1] = 32'hDEAD;
    #1 chk("oor_rdy", req_ready, 2'b10);
    step(); req_valid = 2'b00;
    chk("oor_we", RegWrite, 0);
    chk("oor_err", addr_err, 1);
    chk("oor_reg_hold", write_reg, 2);
    step();
    chk("oor_err_pulse", addr_err, 0);
    chk("oor_mrf1", mrf[1], 0);

    // Pointer advanced past 1 -> back to 0; then a withdrawn request.
    req_valid = 2'b11;
    #1 chk("oor_ptr", req_ready, 2'b01);
    req_valid = 2'b00;
    step();
    chk("withdraw_we", RegWrite, 0);

    // Reset during init at init_cnt=4.
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    chk("mid_reg3", write_reg, 3);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_we", RegWrite, 0);
    chk("mid_rst_reg", write_reg, 0);
    run_init();

    // Reset in the same cycle as an acceptance: the write is dropped.
    req_valid = 2'b01; a_v[0] = 5'd7; d_v[0] = 32'h77; reset = 1'b1;
    step(); reset = 1'b0; req_valid = 2'b00;
    chk("pend_we", RegWrite, 0);
    chk("pend_data", write_data, 0);
    chk("pend_done", init_done, 0);
    step();
    chk("pend_restart_reg", write_reg, 0);
    chk("pend_restart_data", write_data, 0);
    for (int k = 2; k <= 9; k++) step();
    chk("pend_mrf7", mrf[7], 0);
    chk("pend_done2", init_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
